config_menu_ctrl: RTL and testbench
===================================

# config_menu_ctrl

Menu controller for the configuration screen. Turns single-cycle button pulses into cursor movement and per-item setting changes. Owns the 12 setting values and the `ptr_index` that drives the cursor overlay in the config renderer. Sequences every write of a setting's digit tile into the shared 40-column tile buffer that the renderer reads.

## Interface
**Parameters**
- `NUM_VALUES`, default 10: legal values per item are 0..NUM_VALUES-1; range 2..16.
- `DIGIT_BASE`, default 8'h30: tile code written for value 0; value v writes DIGIT_BASE+v.

**Ports**
- `clk_in` input 1: sole clock.
- `rst_in` input 1: asynchronous, active-high reset.
- `btn_up_in` input 1: single-cycle pulse, debounced upstream.
- `btn_down_in` input 1: same.
- `btn_left_in` input 1: same.
- `btn_right_in` input 1: same.
- `btn_select_in` input 1: same.
- `ptr_index_out` output 4: cursor item, 0..12; feeds the renderer's ptr index.
- `settings_out` output 48: item i occupies bits [4i+3:4i].
- `start_out` output 1: one-cycle pulse on select at item 12.
- `buf_write_addr_out` output 10: tile buffer write address.
- `buf_write_data_out` output 8: tile code.
- `buf_write_en_out` output 1: write strobe.
- `busy_out` output 1: high in INIT and WRITE.

## Operation
- Items 0..7 form the left column. Item i is on tile row 3+2i; its digit is at column 10.
- Items 8..11 form the right column. Item i is on tile row 3+2(i-8); its digit is at column 30.
- Item 12 is START.
- Digit address is row*40+col:
  - item 0 → 130
  - item 7 → 690
  - item 8 → 150
  - item 11 → 390
- Address arithmetic uses at least 10 bits; no truncation.
- **FSM states:**
  - INIT: after reset, writes items 0..11 in order, one per cycle (12 cycles), then goes to IDLE.
  - IDLE: acts on buttons.
  - WRITE: one cycle with the strobe high, then back to IDLE.
- All buttons are ignored in INIT and WRITE; pulses are not queued.
- In IDLE, at most one button is acted on per cycle. Priority: select > up > down > right > left.
- **up:**
  - 1..7 → ptr-1; 0 stays 0.
  - 9..11 → ptr-1; 8 stays 8.
  - 12 → 7.
- **down:**
  - 0..6 → ptr+1; 7 → 12.
  - 8..10 → ptr+1; 11 → 12.
  - 12 stays 12.
- **right / left** with ptr ≤ 11:
  - Increment or decrement the item value, with limit behaviour per Configuration.
  - If the value changes, go to WRITE.
  - If the value is unchanged (saturated), stay in IDLE with no write.
- **right / left** with ptr = 12: no effect.
- **select** with ptr = 12: pulse `start_out`. Select elsewhere: no effect.
- **Reset values:**
  - ptr 0, all settings 0, `start_out` 0.
  - write strobe 0, address 0, data 0.
  - `busy_out` 1, state INIT with item counter 0.
- Reset asserted mid-INIT or mid-WRITE: all state returns to reset values immediately. INIT restarts after release; any partial write is abandoned.

## Timing
- All outputs are registered.
- Button pulse sampled at edge k:
  - `ptr_index_out` / `settings_out` change at edge k.
  - `start_out` is high for the cycle following edge k.
- Value change at edge k: `buf_write_en_out`, address and data (the new value) are driven in the cycle after edge k, for exactly one cycle. `busy_out` is high in that same cycle.
- Minimum spacing between accepted value changes: 2 cycles.
- INIT: strobe high for cycles 1..12 after reset release, with addresses for items 0..11 in order. `busy_out` falls at edge 13.
- Address and data are held at their last values when the strobe is low.

## Configuration
- `CONFIG_WRAP_EN` defined:
  - right at NUM_VALUES-1 → 0.
  - left at 0 → NUM_VALUES-1.
  - Every right/left at ptr ≤ 11 produces a write.
- `CONFIG_WRAP_EN` undefined:
  - Values saturate at 0 and NUM_VALUES-1.
  - A saturated press produces no write and no busy cycle.

## Test plan
- Release reset → 12 writes: (130,8'h30), (210,8'h30) … (690,8'h30), then (150,8'h30) … (390,8'h30). `busy_out` falls after the 12th.
- Idle, ptr 0, right ×3 spaced 2 cycles → `settings_out[3:0]` = 3. Last write is (130, 8'h33).
- ptr 0 and up → stays 0. down ×7 → ptr 7; down → 12; up → 7. select at 12 → one `start_out` pulse with no write.
- ptr 9, value 9, right; NUM_VALUES=10:
  - WRAP_EN: value 0, write (230, 8'h30).
  - Without: value 9, no write.
- Up and right in the same cycle → only up acted on. Right pulse during WRITE → ignored, value unchanged.
- Assert `rst_in` at INIT cycle 5 → strobe low immediately. After release, INIT restarts at addr 130.

Source files
------------

// File: rtl/config_menu_ctrl.sv
// Configuration-screen menu controller: cursor, 12 setting values and digit-tile writes.
// Optional CONFIG_WRAP_EN: values wrap around at both ends instead of saturating.
module config_menu_ctrl #(
  parameter int         NUM_VALUES = 10,
  parameter logic [7:0] DIGIT_BASE = 8'h30
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        btn_up_in,
  input  logic        btn_down_in,
  input  logic        btn_left_in,
  input  logic        btn_right_in,
  input  logic        btn_select_in,
  output logic [3:0]  ptr_index_out,
  output logic [47:0] settings_out,
  output logic        start_out,
  output logic [9:0]  buf_write_addr_out,
  output logic [7:0]  buf_write_data_out,
  output logic        buf_write_en_out,
  output logic        busy_out
);

  localparam logic [3:0] MAX_VAL    = 4'(NUM_VALUES - 1);
  localparam logic [3:0] LAST_ITEM  = 4'd11;
  localparam logic [3:0] START_ITEM = 4'd12;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WRITE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       init_cnt_q, init_cnt_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [11:0][3:0] settings_q, settings_d;
  logic             start_q, start_d;
  logic [9:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             wen_q, wen_d;
  logic             busy_q, busy_d;
  logic [3:0]       cur_val, inc_val, dec_val, new_val;

  // Left column items sit 80 tiles apart starting at 130, right column starting at 150.
  function automatic logic [9:0] digit_addr(input logic [3:0] item);
    if (item < 4'd8) digit_addr = 10'd130 + 10'(item) * 10'd80;
    else             digit_addr = 10'd150 + 10'(item - 4'd8) * 10'd80;
  endfunction

  function automatic logic [7:0] digit_code(input logic [3:0] val);
    digit_code = DIGIT_BASE + {4'd0, val};
  endfunction

  always_comb begin
    cur_val = 4'd0;
    if (ptr_q <= LAST_ITEM) cur_val = settings_q[ptr_q];
`ifdef CONFIG_WRAP_EN
    inc_val = (cur_val == MAX_VAL) ? 4'd0 : cur_val + 4'd1;
    dec_val = (cur_val == 4'd0) ? MAX_VAL : cur_val - 4'd1;
`else
    inc_val = (cur_val == MAX_VAL) ? MAX_VAL : cur_val + 4'd1;
    dec_val = (cur_val == 4'd0) ? 4'd0 : cur_val - 4'd1;
`endif
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ptr_d      = ptr_q;
    settings_d = settings_q;
    start_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    wen_d      = 1'b0;
    new_val    = cur_val;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q <= LAST_ITEM) begin
          wen_d      = 1'b1;
          addr_d     = digit_addr(init_cnt_q);
          data_d     = digit_code(settings_q[init_cnt_q]);
          init_cnt_d = init_cnt_q + 4'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (btn_select_in) begin
          start_d = (ptr_q == START_ITEM);
        end else if (btn_up_in) begin
          if (ptr_q == START_ITEM) ptr_d = 4'd7;
          else if (ptr_q != 4'd0 && ptr_q != 4'd8) ptr_d = ptr_q - 4'd1;
        end else if (btn_down_in) begin
          if (ptr_q == 4'd7 || ptr_q == LAST_ITEM) ptr_d = START_ITEM;
          else if (ptr_q != START_ITEM) ptr_d = ptr_q + 4'd1;
        end else if ((btn_right_in || btn_left_in) && ptr_q <= LAST_ITEM) begin
          // A saturated press leaves the value alone and costs no write cycle.
          new_val = btn_right_in ? inc_val : dec_val;
          if (new_val != cur_val) begin
            settings_d[ptr_q] = new_val;
            wen_d             = 1'b1;
            addr_d            = digit_addr(ptr_q);
            data_d            = digit_code(new_val);
            state_d           = S_WRITE;
          end
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_INIT;
      init_cnt_q <= 4'd0;
      ptr_q      <= 4'd0;
      settings_q <= '0;
      start_q    <= 1'b0;
      addr_q     <= 10'd0;
      data_q     <= 8'd0;
      wen_q      <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ptr_q      <= ptr_d;
      settings_q <= settings_d;
      start_q    <= start_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wen_q      <= wen_d;
      busy_q     <= busy_d;
    end
  end

  assign ptr_index_out      = ptr_q;
  assign settings_out       = settings_q;
  assign start_out          = start_q;
  assign buf_write_addr_out = addr_q;
  assign buf_write_data_out = data_q;
  assign buf_write_en_out   = wen_q;
  assign busy_out           = busy_q;

endmodule

// File: tb/tb_config_menu_ctrl.sv
// Self-checking bench for config_menu_ctrl: cycle model from the menu rules plus directed literal checks.
module tb_config_menu_ctrl;

  localparam int         NV   = 10;
  localparam logic [7:0] BASE = 8'h30;

  localparam logic [4:0] B_SEL   = 5'b10000;
  localparam logic [4:0] B_UP    = 5'b01000;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b00010;
  localparam logic [4:0] B_LEFT  = 5'b00001;

  localparam logic [1:0] PH_INIT  = 2'd0;
  localparam logic [1:0] PH_IDLE  = 2'd1;
  localparam logic [1:0] PH_WRITE = 2'd2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        btn_up_in = 1'b0, btn_down_in = 1'b0, btn_left_in = 1'b0;
  logic        btn_right_in = 1'b0, btn_select_in = 1'b0;
  logic [3:0]  ptr_index_out;
  logic [47:0] settings_out;
  logic        start_out;
  logic [9:0]  buf_write_addr_out;
  logic [7:0]  buf_write_data_out;
  logic        buf_write_en_out;
  logic        busy_out;

  config_menu_ctrl #(.NUM_VALUES(NV), .DIGIT_BASE(BASE)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .btn_up_in(btn_up_in), .btn_down_in(btn_down_in), .btn_left_in(btn_left_in),
    .btn_right_in(btn_right_in), .btn_select_in(btn_select_in),
    .ptr_index_out(ptr_index_out), .settings_out(settings_out), .start_out(start_out),
    .buf_write_addr_out(buf_write_addr_out), .buf_write_data_out(buf_write_data_out),
    .buf_write_en_out(buf_write_en_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [1:0]       phase;
    logic [3:0]       init_idx;
    logic [3:0]       ptr;
    logic [11:0][3:0] vals;
    logic             start;
    logic             wen;
    logic [9:0]       addr;
    logic [7:0]       data;
    logic             busy;
  } model_t;

  model_t      m;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [17:0] wlog[$];
  int          init_addrs[12] = '{130, 210, 290, 370, 450, 530, 610, 690, 150, 230, 310, 390};

  // Screen geometry: row 3+2k within a column, digit at column 10 (left) or 30 (right).
  function automatic int tile_addr(int item);
    int row, col;
    row = (item < 8) ? 3 + 2 * item : 3 + 2 * (item - 8);
    col = (item < 8) ? 10 : 30;
    return row * 40 + col;
  endfunction

  function automatic int step_value(int v, int d);
`ifdef CONFIG_WRAP_EN
    return (v + d + NV) % NV;
`else
    if (v + d < 0) return 0;
    if (v + d > NV - 1) return NV - 1;
    return v + d;
`endif
  endfunction

  function automatic int up_of(int p);
    int top;
    if (p == 12) return 7;
    top = (p < 8) ? 0 : 8;
    return (p == top) ? p : p - 1;
  endfunction

  function automatic int down_of(int p);
    int bottom;
    if (p == 12) return 12;
    bottom = (p < 8) ? 7 : 11;
    return (p == bottom) ? 12 : p + 1;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r      = '0;
    r.busy = 1'b1;
    return r;
  endfunction

  function automatic model_t model_step(model_t c, logic [4:0] b);
    model_t n;
    int p, v, nv;
    n       = c;
    n.start = 1'b0;
    n.wen   = 1'b0;
    p       = int'(c.ptr);
    if (c.phase == PH_INIT) begin
      if (c.init_idx < 4'd12) begin
        n.wen      = 1'b1;
        n.addr     = 10'(tile_addr(int'(c.init_idx)));
        n.data     = BASE + 8'(c.vals[c.init_idx]);
        n.init_idx = c.init_idx + 4'd1;
      end else begin
        n.phase = PH_IDLE;
      end
    end else if (c.phase == PH_WRITE) begin
      n.phase = PH_IDLE;
    end else if (b[4]) begin
      n.start = (p == 12);
    end else if (b[3]) begin
      n.ptr = 4'(up_of(p));
    end else if (b[2]) begin
      n.ptr = 4'(down_of(p));
    end else if ((b[1] || b[0]) && p < 12) begin
      v  = int'(c.vals[p]);
      nv = step_value(v, b[1] ? 1 : -1);
      if (nv != v) begin
        n.vals[p] = 4'(nv);
        n.wen     = 1'b1;
        n.addr    = 10'(tile_addr(p));
        n.data    = BASE + 8'(nv);
        n.phase   = PH_WRITE;
      end
    end
    n.busy = (n.phase != PH_IDLE);
    return n;
  endfunction

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) m <= model_reset();
    else m <= model_step(m, {btn_select_in, btn_up_in, btn_down_in, btn_right_in, btn_left_in});
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic compareAll();
    checkOutput("ptr",      64'(ptr_index_out),      64'(m.ptr));
    checkOutput("settings", 64'(settings_out),       64'(m.vals));
    checkOutput("start",    64'(start_out),          64'(m.start));
    checkOutput("wen",      64'(buf_write_en_out),   64'(m.wen));
    checkOutput("addr",     64'(buf_write_addr_out), 64'(m.addr));
    checkOutput("data",     64'(buf_write_data_out), 64'(m.data));
    checkOutput("busy",     64'(busy_out),           64'(m.busy));
  endtask

  task automatic setButtons(input logic [4:0] b);
    {btn_select_in, btn_up_in, btn_down_in, btn_right_in, btn_left_in} = b;
  endtask

  task automatic applyStimulus(input logic [4:0] b, input int gap);
    @(negedge clk_in);
    setButtons(b);
    @(negedge clk_in);
    setButtons(5'b0);
    repeat (gap) @(negedge clk_in);
  endtask

  task automatic waitIdle(input int max_cycles, output int waited);
    waited = 0;
    while (busy_out && waited < max_cycles) begin
      @(negedge clk_in);
      waited++;
    end
    checkOutput("busy_timeout", 64'(busy_out), 64'd0);
  endtask

  task automatic checkInitLog();
    checkOutput("init_count", 64'(wlog.size()), 64'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < wlog.size()) begin
        checkOutput("init_addr", 64'(wlog[i][17:8]), 64'(init_addrs[i]));
        checkOutput("init_data", 64'(wlog[i][7:0]), 64'h30);
      end
    end
  endtask

  task automatic checkLastWrite(input string name, input int addr, input int data);
    if (wlog.size() == 0) checkOutput(name, 64'd0, 64'd1);
    else checkOutput(name, 64'(wlog[wlog.size() - 1]), 64'({10'(addr), 8'(data)}));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int waited;
    setButtons(5'b0);
    fork
      forever begin
        @(negedge clk_in);
        compareAll();
        if (!rst_in && buf_write_en_out) wlog.push_back({buf_write_addr_out, buf_write_data_out});
      end
    join_none

    repeat (3) @(negedge clk_in);
    checkOutput("rst_ptr",      64'(ptr_index_out),      64'd0);
    checkOutput("rst_settings", 64'(settings_out),       64'd0);
    checkOutput("rst_busy",     64'(busy_out),           64'd1);
    checkOutput("rst_wen",      64'(buf_write_en_out),   64'd0);
    checkOutput("rst_addr",     64'(buf_write_addr_out), 64'd0);
    checkOutput("rst_data",     64'(buf_write_data_out), 64'd0);
    checkOutput("rst_start",    64'(start_out),          64'd0);

    rst_in = 1'b0;
    waitIdle(40, waited);
    checkOutput("init_cycles", 64'(waited), 64'd13);
    checkInitLog();

    wlog.delete();
    repeat (3) applyStimulus(B_RIGHT, 1);
    checkOutput("item0_val", 64'(settings_out[3:0]), 64'd3);
    checkOutput("item0_writes", 64'(wlog.size()), 64'd3);
    checkLastWrite("item0_last_write", 130, 8'h33);

    applyStimulus(B_UP, 0);
    checkOutput("ptr_top_stays", 64'(ptr_index_out), 64'd0);
    repeat (7) applyStimulus(B_DOWN, 0);
    checkOutput("ptr_down7", 64'(ptr_index_out), 64'd7);
    applyStimulus(B_DOWN, 0);
    checkOutput("ptr_to_start", 64'(ptr_index_out), 64'd12);
    applyStimulus(B_UP, 0);
    checkOutput("ptr_from_start", 64'(ptr_index_out), 64'd7);
    applyStimulus(B_DOWN, 0);

    wlog.delete();
    @(negedge clk_in);
    setButtons(B_SEL);
    @(negedge clk_in);
    setButtons(5'b0);
    checkOutput("start_pulse", 64'(start_out), 64'd1);
    checkOutput("start_no_write", 64'(buf_write_en_out), 64'd0);
    @(negedge clk_in);
    checkOutput("start_one_cycle", 64'(start_out), 64'd0);
    checkOutput("start_ptr", 64'(ptr_index_out), 64'd12);

    applyStimulus(B_UP, 0);
    repeat (6) applyStimulus(B_UP, 0);
    checkOutput("ptr_item1", 64'(ptr_index_out), 64'd1);
    wlog.delete();
    repeat (9) applyStimulus(B_RIGHT, 1);
    checkOutput("item1_max", 64'(settings_out[7:4]), 64'd9);
    checkOutput("item1_writes", 64'(wlog.size()), 64'd9);
    checkLastWrite("item1_last_write", 210, 8'h39);

    wlog.delete();
    applyStimulus(B_RIGHT, 1);
`ifdef CONFIG_WRAP_EN
    checkOutput("item1_wrap_val", 64'(settings_out[7:4]), 64'd0);
    checkOutput("item1_wrap_writes", 64'(wlog.size()), 64'd1);
    checkLastWrite("item1_wrap_write", 210, 8'h30);
`else
    checkOutput("item1_sat_val", 64'(settings_out[7:4]), 64'd9);
    checkOutput("item1_sat_writes", 64'(wlog.size()), 64'd0);
`endif

    applyStimulus(B_DOWN, 0);
    wlog.delete();
    applyStimulus(B_LEFT, 1);
`ifdef CONFIG_WRAP_EN
    checkOutput("item2_wrap_val", 64'(settings_out[11:8]), 64'd9);
    checkLastWrite("item2_wrap_write", 290, 8'h39);
`else
    checkOutput("item2_sat_val", 64'(settings_out[11:8]), 64'd0);
    checkOutput("item2_sat_writes", 64'(wlog.size()), 64'd0);
`endif

    wlog.delete();
    applyStimulus(B_UP | B_RIGHT, 1);
    checkOutput("prio_ptr", 64'(ptr_index_out), 64'd1);
    checkOutput("prio_no_write", 64'(wlog.size()), 64'd0);
`ifdef CONFIG_WRAP_EN
    checkOutput("prio_item1_val", 64'(settings_out[7:4]), 64'd0);
`else
    checkOutput("prio_item1_val", 64'(settings_out[7:4]), 64'd9);
`endif

    applyStimulus(B_DOWN, 0);
    applyStimulus(B_DOWN, 0);
    wlog.delete();
    @(negedge clk_in);
    setButtons(B_RIGHT);
    repeat (2) @(negedge clk_in);
    setButtons(5'b0);
    @(negedge clk_in);
    checkOutput("busy_ignore_val", 64'(settings_out[15:12]), 64'd1);
    checkOutput("busy_ignore_writes", 64'(wlog.size()), 64'd1);

    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (5) @(negedge clk_in);
    checkOutput("init5_wen", 64'(buf_write_en_out), 64'd1);
    checkOutput("init5_addr", 64'(buf_write_addr_out), 64'd450);
    #2 rst_in = 1'b1;
    #1;
    checkOutput("midrst_wen", 64'(buf_write_en_out), 64'd0);
    checkOutput("midrst_busy", 64'(busy_out), 64'd1);
    checkOutput("midrst_addr", 64'(buf_write_addr_out), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    wlog.delete();
    waitIdle(40, waited);
    checkOutput("reinit_cycles", 64'(waited), 64'd13);
    checkInitLog();
    checkOutput("reinit_settings", 64'(settings_out), 64'd0);

    repeat (2) @(negedge clk_in);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
